// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: word width, Galois taps, step function and checker FSM states.
// Used by both the generator and the sync checker so their taps cannot drift apart.
package lfsr_pkg;

   localparam int              LFSR_WIDTH = 8;
   localparam logic [7:0]      LFSR_POLY  = 8'h1D;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
      return {s[LFSR_WIDTH-2:0], 1'b0} ^ (s[LFSR_WIDTH-1] ? LFSR_POLY : '0);
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step advance of a Galois LFSR word.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY)
) (
   input  logic [WIDTH-1:0] state_i,
   output logic [WIDTH-1:0] next_o
);

   // The default configuration reuses the shared function so taps match the generator exactly.
   if (WIDTH == LFSR_WIDTH && POLY == WIDTH'(LFSR_POLY)) begin : g_pkg
      assign next_o = lfsr_next(state_i);
   end else begin : g_generic
      assign next_o = {state_i[WIDTH-2:0], 1'b0} ^ (state_i[WIDTH-1] ? POLY : '0);
   end

endmodule

// File: rtl/lfsr_sync_checker.sv
// Seedless LFSR stream checker: locks onto received words, then flywheels a local
// predictor and flags/counts mismatches while locked.
//
//   state  | meaning
//   SEARCH | waiting for a non-zero word to seed the predictor
//   VERIFY | seeded; counting consecutive correct predictions towards lock
//   LOCKED | predictor free-runs; mismatches pulse error and are counted
module lfsr_sync_checker
   import lfsr_pkg::*;
#(
   parameter int               WIDTH      = LFSR_WIDTH,
   parameter logic [WIDTH-1:0] POLY       = WIDTH'(LFSR_POLY),
   parameter int               LOCK_CNT   = 4,
   parameter int               UNLOCK_CNT = 3,
   parameter int               CNT_W      = 16
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             error,
   output logic [CNT_W-1:0] err_count
);

   localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
   localparam int GB_W = $clog2(CMAX + 1);
   localparam logic [GB_W-1:0] LOCK_V   = GB_W'(LOCK_CNT);
   localparam logic [GB_W-1:0] UNLOCK_V = GB_W'(UNLOCK_CNT);

   chk_state_e       state_q, state_d;
   logic [WIDTH-1:0] pred_q, pred_d;
   logic [GB_W-1:0]  good_q, good_d;
   logic [GB_W-1:0]  bad_q, bad_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             error_q, error_d;
   logic             locked_q, locked_d;

   logic [WIDTH-1:0] pred_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [GB_W-1:0]  good_inc;
   logic [GB_W-1:0]  bad_inc;

   lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step_pred (
      .state_i (pred_q),
      .next_o  (pred_nxt)
   );

   lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step_data (
      .state_i (data_in),
      .next_o  (data_nxt)
   );

   assign good_inc = good_q + GB_W'(1);
   assign bad_inc  = bad_q + GB_W'(1);

   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      good_d  = good_q;
      bad_d   = bad_q;
      cnt_d   = cnt_q;
      error_d = 1'b0;

      if (data_valid) begin
         case (state_q)
            SEARCH: begin
               if (data_in != '0) begin
                  pred_d  = data_nxt;
                  good_d  = '0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               pred_d = data_nxt;
               if (data_in == pred_q) begin
                  good_d = good_inc;
                  if (good_inc == LOCK_V) begin
                     state_d = LOCKED;
                     bad_d   = '0;
                  end
               end else begin
                  good_d = '0;
                  // All-zero is the LFSR lockup word and can never be a valid seed.
                  if (data_in == '0) begin
                     state_d = SEARCH;
                  end
               end
            end
            LOCKED: begin
               pred_d = pred_nxt;
               if (data_in == pred_q) begin
                  bad_d = '0;
               end else begin
                  error_d = 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  bad_d = bad_inc;
                  if (bad_inc == UNLOCK_V) begin
                     state_d = SEARCH;
                     bad_d   = '0;
                  end
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end

      if (clr_cnt) begin
         cnt_d = '0;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q  <= SEARCH;
         pred_q   <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         cnt_q    <= '0;
         error_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pred_q   <= pred_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         cnt_q    <= cnt_d;
         error_q  <= error_d;
         locked_q <= locked_d;
      end
   end

   assign locked    = locked_q;
   assign error     = error_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Directed bench for lfsr_sync_checker: default instance plus a small-counter instance
// (CNT_W=2, UNLOCK_CNT=8) for saturation and clear-versus-error priority.
module tb_lfsr_sync_checker;

   logic       clk;
   logic       res_n, data_valid, clr_cnt;
   logic [7:0] data_in;
   logic       locked, error;
   logic [15:0] err_count;

   logic       r2_n, v2, c2;
   logic [7:0] d2;
   logic       l2, e2;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   lfsr_sync_checker dut (
      .clk        (clk),
      .res_n      (res_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .clr_cnt    (clr_cnt),
      .locked     (locked),
      .error      (error),
      .err_count  (err_count)
   );

   lfsr_sync_checker #(.CNT_W(2), .UNLOCK_CNT(8)) dut2 (
      .clk        (clk),
      .res_n      (r2_n),
      .data_in    (d2),
      .data_valid (v2),
      .clr_cnt    (c2),
      .locked     (l2),
      .error      (e2),
      .err_count  (cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] w);
      data_in    = w;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      data_in    = 8'h5A;
   endtask

   task automatic send2(input logic [7:0] w);
      d2 = w;
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
      d2 = 8'hA5;
   endtask

   initial begin
      res_n = 1'b0; data_valid = 1'b0; clr_cnt = 1'b0; data_in = 8'h00;
      r2_n  = 1'b0; v2 = 1'b0; c2 = 1'b0; d2 = 8'h00;
      tick();
      tick();
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_error",  {31'd0, error},  32'd0);
      chk("rst_cnt",    {16'd0, err_count}, 32'd0);
      res_n = 1'b1;
      r2_n  = 1'b1;

      // zero word in SEARCH is ignored
      send(8'h00);
      chk("zero_search_locked", {31'd0, locked}, 32'd0);

      // lock: seed 57, then four matches
      send(8'h57); send(8'hAE); send(8'h41); send(8'h82);
      chk("prelock_locked", {31'd0, locked}, 32'd0);
      send(8'h19);
      chk("lock_locked", {31'd0, locked}, 32'd1);
      chk("lock_error",  {31'd0, error},  32'd0);
      chk("lock_cnt",    {16'd0, err_count}, 32'd0);

      // single error (expect 32), flywheel continues with 64, C8
      send(8'h33);
      chk("err_pulse",  {31'd0, error},  32'd1);
      chk("err_cnt",    {16'd0, err_count}, 32'd1);
      chk("err_locked", {31'd0, locked}, 32'd1);
      send(8'h64);
      chk("fly64_error", {31'd0, error}, 32'd0);
      send(8'hC8);
      chk("flyC8_error",  {31'd0, error},  32'd0);
      chk("flyC8_locked", {31'd0, locked}, 32'd1);
      chk("flyC8_cnt",    {16'd0, err_count}, 32'd1);

      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("clr_idle_cnt", {16'd0, err_count}, 32'd0);

      // unlock after three consecutive mismatches (expected 8D, 07, 0E)
      send(8'hFF);
      chk("unl1_error", {31'd0, error}, 32'd1);
      send(8'hFF);
      chk("unl2_locked", {31'd0, locked}, 32'd1);
      send(8'hFF);
      chk("unl3_error",  {31'd0, error},  32'd1);
      chk("unl3_cnt",    {16'd0, err_count}, 32'd3);
      chk("unl3_locked", {31'd0, locked}, 32'd0);

      // relock: seed 8D, then 07, 0E, 1C, 38
      send(8'h8D); send(8'h07); send(8'h0E); send(8'h1C);
      chk("relock_pre", {31'd0, locked}, 32'd0);
      send(8'h38);
      chk("relock_locked", {31'd0, locked}, 32'd1);
      chk("relock_error",  {31'd0, error},  32'd0);

      // gaps with junk on data_in do not advance or disturb the predictor
      data_in = 8'hAA;
      tick(); tick(); tick();
      chk("gap_error",  {31'd0, error},  32'd0);
      chk("gap_locked", {31'd0, locked}, 32'd1);
      send(8'h70);
      data_in = 8'h13;
      tick(); tick();
      send(8'hE0);
      chk("gapE0_error", {31'd0, error}, 32'd0);
      chk("gapE0_cnt",   {16'd0, err_count}, 32'd3);

      // mismatch at DD, then an idle cycle drops error, then A7 matches
      send(8'h00);
      chk("dd_error", {31'd0, error}, 32'd1);
      chk("dd_cnt",   {16'd0, err_count}, 32'd4);
      tick();
      chk("idle_error", {31'd0, error}, 32'd0);
      send(8'hA7);
      chk("a7_error",  {31'd0, error},  32'd0);
      chk("a7_locked", {31'd0, locked}, 32'd1);

      // reset while locked; next word is a fresh seed
      res_n = 1'b0;
      tick();
      res_n = 1'b1;
      chk("mrst_locked", {31'd0, locked}, 32'd0);
      chk("mrst_cnt",    {16'd0, err_count}, 32'd0);
      send(8'hA5);
      chk("mrst_seed_locked", {31'd0, locked}, 32'd0);
      chk("mrst_seed_error",  {31'd0, error},  32'd0);
      send(8'h57); send(8'hAE); send(8'h41);
      chk("mrst_pre_locked", {31'd0, locked}, 32'd0);
      send(8'h82);
      chk("mrst_relock", {31'd0, locked}, 32'd1);

      // saturation on the 2-bit counter instance
      send2(8'h57); send2(8'hAE); send2(8'h41); send2(8'h82); send2(8'h19);
      chk("sat_locked", {31'd0, l2}, 32'd1);
      send2(8'hFF); chk("sat_c1", {30'd0, cnt2}, 32'd1);
      send2(8'h64); chk("sat_g1", {31'd0, e2},   32'd0);
      send2(8'hFF); chk("sat_c2", {30'd0, cnt2}, 32'd2);
      send2(8'h8D);
      send2(8'hFF); chk("sat_c3", {30'd0, cnt2}, 32'd3);
      send2(8'h0E);
      send2(8'hFF); chk("sat_c4", {30'd0, cnt2}, 32'd3);
      chk("sat_e4", {31'd0, e2}, 32'd1);
      send2(8'h38);
      send2(8'hFF); chk("sat_c5", {30'd0, cnt2}, 32'd3);
      send2(8'hE0);
      chk("sat_still_locked", {31'd0, l2}, 32'd1);

      // clear coincident with a counted error (expected DD)
      c2 = 1'b1;
      send2(8'hFF);
      c2 = 1'b0;
      chk("clrerr_cnt",   {30'd0, cnt2}, 32'd0);
      chk("clrerr_error", {31'd0, e2},   32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
